// File: rtl/regfile_port_arbiter.sv
// Register file port arbiter.
// Sits between the core pipeline, the debug/host port and a 32x32 register
// file with two synchronous read ports (1-cycle latency) and one write port.
// After reset it sweeps x1..x(NUM_REGS-1) to zero, then shares the ports:
// the core has fixed priority, and debug is protected by a starvation guard
// that stalls the core for one cycle after DBG_STARVE_LIMIT blocked cycles.
//
// Optional feature (macro REGFILE_ARB_BYPASS_EN): read data returned one
// cycle after a read is forwarded from a write made in the same cycle as the
// read, so read data is never stale.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   core_rd_valid/rs1/rs2, core_wr_valid/rd/wdata   core requests
//   core_stall           core requests ignored this cycle (core holds them)
//   core_rvalid, core_rdata1/2                      core read return
//   dbg_req/we/addr/wdata, dbg_ready                debug request/grant
//   dbg_rvalid, dbg_rdata                           debug read return
//   init_done            init sweep complete
//   rf_addr1/2, rf_rdata1/2                         register file read ports
//   rf_addr3, rf_regwrite, rf_datain                register file write port
module regfile_port_arbiter #(
  parameter int DBG_STARVE_LIMIT = 8,
  parameter int NUM_REGS         = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_rd_valid,
  input  logic [4:0]  core_rs1,
  input  logic [4:0]  core_rs2,
  input  logic        core_wr_valid,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_rvalid,
  output logic [31:0] core_rdata1,
  output logic [31:0] core_rdata2,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        init_done,
  output logic [4:0]  rf_addr1,
  output logic [4:0]  rf_addr2,
  output logic [4:0]  rf_addr3,
  output logic        rf_regwrite,
  output logic [31:0] rf_datain,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [4:0] LAST_ADDR   = 5'(NUM_REGS - 1);
  localparam logic [7:0] STARVE_LAST = 8'(DBG_STARVE_LIMIT - 1);

  logic [0:0] state_q, state_d;
  logic [4:0] init_cnt_q, init_cnt_d;
  logic       init_done_q, init_done_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       force_dbg_q, force_dbg_d;
  logic       core_rvalid_q, core_rvalid_d;
  logic       dbg_rvalid_q, dbg_rvalid_d;

  logic run;
  logic core_rd_acc, core_wr_acc, dbg_rd_gnt, dbg_wr_gnt, dbg_blocked;

  assign run = (state_q == ST_RUN);

  // force_dbg takes both core ports away for one cycle
  assign core_rd_acc = run && core_rd_valid && !force_dbg_q;
  assign core_wr_acc = run && core_wr_valid && !force_dbg_q;
  // Debug only competes for the port type it needs
  assign dbg_rd_gnt  = run && dbg_req && !dbg_we && (!core_rd_valid || force_dbg_q);
  assign dbg_wr_gnt  = run && dbg_req &&  dbg_we && (!core_wr_valid || force_dbg_q);
  assign dbg_blocked = run && dbg_req && !dbg_ready;

  assign dbg_ready   = dbg_rd_gnt || dbg_wr_gnt;
  assign core_stall  = !run || force_dbg_q;
  assign init_done   = init_done_q;
  assign core_rvalid = core_rvalid_q;
  assign dbg_rvalid  = dbg_rvalid_q;

  // Register file port muxing
  always_comb begin
    rf_addr1    = '0;
    rf_addr2    = '0;
    rf_addr3    = '0;
    rf_datain   = '0;
    rf_regwrite = 1'b0;
    if (!run) begin
      rf_regwrite = 1'b1;
      rf_addr3    = init_cnt_q;
    end else begin
      if (core_rd_acc) begin
        rf_addr1 = core_rs1;
        rf_addr2 = core_rs2;
      end else if (dbg_rd_gnt) begin
        rf_addr2 = dbg_addr;
      end
      if (core_wr_acc) begin
        rf_regwrite = 1'b1;
        rf_addr3    = core_rd;
        rf_datain   = core_wdata;
      end else if (dbg_wr_gnt) begin
        rf_regwrite = 1'b1;
        rf_addr3    = dbg_addr;
        rf_datain   = dbg_wdata;
      end
    end
  end

  // Sequencing, starvation guard and read-return tracking
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    init_done_d   = init_done_q;
    starve_cnt_d  = '0;
    force_dbg_d   = 1'b0;
    core_rvalid_d = core_rd_acc;
    dbg_rvalid_d  = dbg_rd_gnt;
    if (!run) begin
      init_cnt_d = init_cnt_q + 5'd1;
      if (init_cnt_q == LAST_ADDR) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
    // Counter clears on any grant or idle request; force lasts one cycle
    if (dbg_blocked) begin
      if (starve_cnt_q == STARVE_LAST) force_dbg_d = 1'b1;
      else                             starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= 5'd1;
      init_done_q   <= 1'b0;
      starve_cnt_q  <= '0;
      force_dbg_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      init_done_q   <= init_done_d;
      starve_cnt_q  <= starve_cnt_d;
      force_dbg_q   <= force_dbg_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  // Capture read addresses and the granted write together; on return, a hit
  // on a nonzero written register returns the new data. Debug reads share
  // read port 2, so one comparator covers core port 2 and debug.
  logic [4:0]  rd_addr1_q, rd_addr1_d, rd_addr2_q, rd_addr2_d, byp_addr_q, byp_addr_d;
  logic [31:0] byp_data_q, byp_data_d;
  logic        byp_vld_q, byp_vld_d;
  logic        hit1, hit2;

  always_comb begin
    rd_addr1_d = rf_addr1;
    rd_addr2_d = rf_addr2;
    byp_vld_d  = run && rf_regwrite && (rf_addr3 != 5'd0);
    byp_addr_d = rf_addr3;
    byp_data_d = rf_datain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      byp_vld_q  <= 1'b0;
      byp_addr_q <= '0;
      byp_data_q <= '0;
    end else begin
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
      byp_vld_q  <= byp_vld_d;
      byp_addr_q <= byp_addr_d;
      byp_data_q <= byp_data_d;
    end
  end

  assign hit1        = byp_vld_q && (rd_addr1_q == byp_addr_q);
  assign hit2        = byp_vld_q && (rd_addr2_q == byp_addr_q);
  assign core_rdata1 = hit1 ? byp_data_q : rf_rdata1;
  assign core_rdata2 = hit2 ? byp_data_q : rf_rdata2;
  assign dbg_rdata   = hit2 ? byp_data_q : rf_rdata2;
`else
  assign core_rdata1 = rf_rdata1;
  assign core_rdata2 = rf_rdata2;
  assign dbg_rdata   = rf_rdata2;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: register file model, init sweep and reset
// restart, table-driven port vectors, starvation sequence, then randomized
// traffic checked against an architectural reference model.
module tb_regfile_port_arbiter;

`ifdef REGFILE_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LIM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        core_rd_valid, core_wr_valid, dbg_req, dbg_we;
  logic [4:0]  core_rs1, core_rs2, core_rd, dbg_addr;
  logic [31:0] core_wdata, dbg_wdata;
  logic        core_stall, core_rvalid, dbg_ready, dbg_rvalid, init_done, rf_regwrite;
  logic [31:0] core_rdata1, core_rdata2, dbg_rdata, rf_datain, rf_rdata1, rf_rdata2;
  logic [4:0]  rf_addr1, rf_addr2, rf_addr3;

  regfile_port_arbiter #(.DBG_STARVE_LIMIT(LIM), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .core_rd_valid(core_rd_valid), .core_rs1(core_rs1), .core_rs2(core_rs2),
    .core_wr_valid(core_wr_valid), .core_rd(core_rd), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rdata1(core_rdata1), .core_rdata2(core_rdata2),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .init_done(init_done),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
    .rf_regwrite(rf_regwrite), .rf_datain(rf_datain),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  // Register file: synchronous reads, x0 reads zero and ignores writes
  logic [31:0] mem [32];
  always @(posedge clk) begin
    rf_rdata1 <= (rf_addr1 == 5'd0) ? 32'd0 : mem[rf_addr1];
    rf_rdata2 <= (rf_addr2 == 5'd0) ? 32'd0 : mem[rf_addr2];
    if (rf_regwrite && rf_addr3 != 5'd0) mem[rf_addr3] <= rf_datain;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural register contents plus request rules
  logic [31:0] arch [32];
  int          m_blk = 0;
  bit          m_force = 0, m_last_gnt = 0;
  bit          p_crv = 0, p_drv = 0;
  logic [31:0] p_rd1, p_rd2, p_drd;

  task automatic model_cycle(input bit cmp);
    logic [31:0] nxt [32];
    bit crd, cwr, dg, wv;
    logic [4:0] wa, ea2;
    logic [31:0] wd;
    if (cmp) begin
      chk("rnd core_rvalid", {31'd0, core_rvalid}, {31'd0, p_crv});
      if (p_crv) begin
        chk("rnd core_rdata1", core_rdata1, p_rd1);
        chk("rnd core_rdata2", core_rdata2, p_rd2);
      end
      chk("rnd dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, p_drv});
      if (p_drv) chk("rnd dbg_rdata", dbg_rdata, p_drd);
    end
    crd = core_rd_valid && !m_force;
    cwr = core_wr_valid && !m_force;
    dg  = dbg_req && (m_force || (dbg_we ? !core_wr_valid : !core_rd_valid));
    wv  = cwr || (dg && dbg_we);
    wa  = cwr ? core_rd : dbg_addr;
    wd  = cwr ? core_wdata : dbg_wdata;
    ea2 = crd ? core_rs2 : ((dg && !dbg_we) ? dbg_addr : 5'd0);
    if (cmp) begin
      chk("rnd core_stall", {31'd0, core_stall}, {31'd0, m_force});
      chk("rnd dbg_ready", {31'd0, dbg_ready}, {31'd0, dg});
      chk("rnd rf_regwrite", {31'd0, rf_regwrite}, {31'd0, wv});
      chk("rnd rf_addr1", {27'd0, rf_addr1}, {27'd0, crd ? core_rs1 : 5'd0});
      chk("rnd rf_addr2", {27'd0, rf_addr2}, {27'd0, ea2});
      if (wv) begin
        chk("rnd rf_addr3", {27'd0, rf_addr3}, {27'd0, wa});
        chk("rnd rf_datain", rf_datain, wd);
      end
    end
    nxt = arch;
    if (wv && wa != 5'd0) nxt[wa] = wd;
    p_crv = crd;
    p_rd1 = BYP ? nxt[core_rs1] : arch[core_rs1];
    p_rd2 = BYP ? nxt[core_rs2] : arch[core_rs2];
    p_drv = dg && !dbg_we;
    p_drd = BYP ? nxt[dbg_addr] : arch[dbg_addr];
    arch = nxt;
    if (dbg_req && !dg) begin
      m_blk++;
      m_force = (m_blk == LIM);
      if (m_force) m_blk = 0;
    end else begin
      m_blk = 0;
      m_force = 0;
    end
    m_last_gnt = dg;
  endtask

  task automatic finish_cycle(input bit cmp);
    model_cycle(cmp);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    core_rd_valid = 0; core_rs1 = 0; core_rs2 = 0;
    core_wr_valid = 0; core_rd = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  // Checks cycles 1..n of a sweep; caller is at the negedge of cycle 1
  task automatic sweep(input int n);
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("init%0d regwrite", k), {31'd0, rf_regwrite}, 32'd1);
      chk($sformatf("init%0d addr3", k), {27'd0, rf_addr3}, k);
      chk($sformatf("init%0d datain", k), rf_datain, 32'd0);
      chk($sformatf("init%0d stall", k), {31'd0, core_stall}, 32'd1);
      chk($sformatf("init%0d init_done", k), {31'd0, init_done}, 32'd0);
      chk($sformatf("init%0d dbg_ready", k), {31'd0, dbg_ready}, 32'd0);
    end
  endtask

  typedef struct {
    logic crv; logic [4:0] rs1, rs2; logic cwv; logic [4:0] rd; logic [31:0] wd;
    logic dreq, dwe; logic [4:0] da; logic [31:0] dwd;
    logic e_stall, e_rdy, e_we; logic [4:0] e_a1, e_a2, e_a3; logic [31:0] e_din;
    logic e_crv; logic [31:0] e_rd1, e_rd2; logic e_drv; logic [31:0] e_drd;
  } vec_t;

  function automatic vec_t mk(
    logic crv, logic [4:0] rs1, logic [4:0] rs2, logic cwv, logic [4:0] rd, logic [31:0] wd,
    logic dreq, logic dwe, logic [4:0] da, logic [31:0] dwd,
    logic e_stall, logic e_rdy, logic e_we, logic [4:0] e_a1, logic [4:0] e_a2,
    logic [4:0] e_a3, logic [31:0] e_din,
    logic e_crv, logic [31:0] e_rd1, logic [31:0] e_rd2, logic e_drv, logic [31:0] e_drd);
    vec_t v;
    v.crv = crv; v.rs1 = rs1; v.rs2 = rs2; v.cwv = cwv; v.rd = rd; v.wd = wd;
    v.dreq = dreq; v.dwe = dwe; v.da = da; v.dwd = dwd;
    v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_we = e_we;
    v.e_a1 = e_a1; v.e_a2 = e_a2; v.e_a3 = e_a3; v.e_din = e_din;
    v.e_crv = e_crv; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_drv = e_drv; v.e_drd = e_drd;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    // Read returns in each row describe the previous row's requests
    tbl[0]  = mk(0,0,0, 1,5,32'hDEADBEEF, 0,0,0,0,  0,0,1, 0,0,5,32'hDEADBEEF, 0,0,0, 0,0);
    tbl[1]  = mk(1,5,0, 0,0,0, 0,0,0,0,             0,0,0, 5,0,0,0, 0,0,0, 0,0);
    tbl[2]  = mk(1,7,5, 1,7,32'h12345678, 0,0,0,0,  0,0,1, 7,5,7,32'h12345678, 1,32'hDEADBEEF,0, 0,0);
    tbl[3]  = mk(0,0,0, 0,0,0, 0,0,0,0,             0,0,0, 0,0,0,0,
                 1, BYP ? 32'h12345678 : 32'h0, 32'hDEADBEEF, 0,0);
    tbl[4]  = mk(0,0,0, 0,0,0, 1,1,0,32'hFFFFFFFF,  0,1,1, 0,0,0,32'hFFFFFFFF, 0,0,0, 0,0);
    tbl[5]  = mk(0,0,0, 0,0,0, 1,0,0,0,             0,1,0, 0,0,0,0, 0,0,0, 0,0);
    tbl[6]  = mk(0,0,0, 1,5,32'hCAFEF00D, 1,0,5,0,  0,1,1, 0,5,5,32'hCAFEF00D, 0,0,0, 1,32'h0);
    tbl[7]  = mk(0,0,0, 0,0,0, 0,0,0,0,             0,0,0, 0,0,0,0,
                 0,0,0, 1, BYP ? 32'hCAFEF00D : 32'hDEADBEEF);
    tbl[8]  = mk(1,0,7, 0,0,0, 1,1,9,32'h55,        0,1,1, 0,7,9,32'h55, 0,0,0, 0,0);
    tbl[9]  = mk(0,0,0, 1,9,32'h66, 1,1,10,32'h77,  0,0,1, 0,0,9,32'h66, 1,32'h0,32'h12345678, 0,0);
    tbl[10] = mk(0,0,0, 0,0,0, 0,0,0,0,             0,0,0, 0,0,0,0, 0,0,0, 0,0);
    tbl[11] = mk(1,9,10, 0,0,0, 0,0,0,0,            0,0,0, 9,10,0,0, 0,0,0, 0,0);
    tbl[12] = mk(0,0,0, 0,0,0, 0,0,0,0,             0,0,0, 0,0,0,0, 1,32'h66,32'h0, 0,0);
    tbl[13] = mk(0,0,0, 1,0,32'hFFFFFFFF, 1,0,0,0,  0,1,1, 0,0,0,32'hFFFFFFFF, 0,0,0, 0,0);
    tbl[14] = mk(0,0,0, 0,0,0, 0,0,0,0,             0,0,0, 0,0,0,0, 0,0,0, 1,32'h0);

    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    idle_inputs();

    // Reset for two cycles
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset init_done", {31'd0, init_done}, 32'd0);
    chk("reset core_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("reset dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("reset core_stall", {31'd0, core_stall}, 32'd1);
    chk("reset rf_addr3", {27'd0, rf_addr3}, 32'd1);
    reset = 0;

    // Partial sweep, reset at counter 15, then a full sweep
    sweep(15);
    reset = 1;
    @(negedge clk);
    chk("restart addr3", {27'd0, rf_addr3}, 32'd1);
    reset = 0;
    sweep(31);
    @(negedge clk);
    chk("cycle32 init_done", {31'd0, init_done}, 32'd1);
    chk("cycle32 core_stall", {31'd0, core_stall}, 32'd0);
    @(posedge clk); #1;

    // Table-driven port vectors
    for (int i = 0; i < 15; i++) begin
      core_rd_valid = tbl[i].crv; core_rs1 = tbl[i].rs1; core_rs2 = tbl[i].rs2;
      core_wr_valid = tbl[i].cwv; core_rd = tbl[i].rd; core_wdata = tbl[i].wd;
      dbg_req = tbl[i].dreq; dbg_we = tbl[i].dwe; dbg_addr = tbl[i].da; dbg_wdata = tbl[i].dwd;
      @(negedge clk);
      chk($sformatf("row%0d stall", i), {31'd0, core_stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("row%0d ready", i), {31'd0, dbg_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("row%0d regwrite", i), {31'd0, rf_regwrite}, {31'd0, tbl[i].e_we});
      chk($sformatf("row%0d addr1", i), {27'd0, rf_addr1}, {27'd0, tbl[i].e_a1});
      chk($sformatf("row%0d addr2", i), {27'd0, rf_addr2}, {27'd0, tbl[i].e_a2});
      if (tbl[i].e_we) begin
        chk($sformatf("row%0d addr3", i), {27'd0, rf_addr3}, {27'd0, tbl[i].e_a3});
        chk($sformatf("row%0d datain", i), rf_datain, tbl[i].e_din);
      end
      chk($sformatf("row%0d core_rvalid", i), {31'd0, core_rvalid}, {31'd0, tbl[i].e_crv});
      if (tbl[i].e_crv) begin
        chk($sformatf("row%0d rdata1", i), core_rdata1, tbl[i].e_rd1);
        chk($sformatf("row%0d rdata2", i), core_rdata2, tbl[i].e_rd2);
      end
      chk($sformatf("row%0d dbg_rvalid", i), {31'd0, dbg_rvalid}, {31'd0, tbl[i].e_drv});
      if (tbl[i].e_drv) chk($sformatf("row%0d dbg_rdata", i), dbg_rdata, tbl[i].e_drd);
      finish_cycle(0);
    end

    // Starvation: x3 = 0x33, then debug read of x3 against a held core read
    idle_inputs();
    core_wr_valid = 1; core_rd = 3; core_wdata = 32'h33;
    @(negedge clk);
    finish_cycle(0);
    idle_inputs();
    core_rd_valid = 1; core_rs1 = 1; core_rs2 = 2;
    dbg_req = 1; dbg_we = 0; dbg_addr = 3;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= LIM) begin
        chk($sformatf("starve c%0d ready", c), {31'd0, dbg_ready}, 32'd0);
        chk($sformatf("starve c%0d stall", c), {31'd0, core_stall}, 32'd0);
      end else begin
        chk("starve grant ready", {31'd0, dbg_ready}, 32'd1);
        chk("starve grant stall", {31'd0, core_stall}, 32'd1);
        chk("starve grant addr2", {27'd0, rf_addr2}, 32'd3);
        chk("starve grant addr1", {27'd0, rf_addr1}, 32'd0);
      end
      if (c >= 2) chk($sformatf("starve c%0d core_rvalid", c), {31'd0, core_rvalid}, 32'd1);
      finish_cycle(0);
    end
    dbg_req = 0;
    @(negedge clk);
    chk("starve dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("starve dbg_rdata", dbg_rdata, 32'h33);
    chk("starve stalled read dropped", {31'd0, core_rvalid}, 32'd0);
    finish_cycle(0);
    core_rd_valid = 0;
    @(negedge clk);
    chk("starve resume core_rvalid", {31'd0, core_rvalid}, 32'd1);
    finish_cycle(0);

    // Randomized traffic; debug holds its request until granted
    for (int n = 0; n < 600; n++) begin
      core_rd_valid = ($urandom_range(0, 7) != 0);
      core_rs1      = 5'($urandom_range(0, 7));
      core_rs2      = 5'($urandom_range(0, 7));
      core_wr_valid = ($urandom_range(0, 1) == 1);
      core_rd       = 5'($urandom_range(0, 7));
      core_wdata    = $urandom;
      if (!dbg_req || m_last_gnt) begin
        dbg_req   = ($urandom_range(0, 1) == 1);
        dbg_we    = ($urandom_range(0, 2) == 0);
        dbg_addr  = 5'($urandom_range(0, 7));
        dbg_wdata = $urandom;
      end
      @(negedge clk);
      finish_cycle(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Sits between the core pipeline, the debug/host access port and the 32x32 register file.
- Register file interface: two synchronous read ports (1-cycle latency) and one write port. Writes to address 0 are ignored by the register file.
- After reset, sequences an initialisation sweep that clears x1..x31.
- Then shares the read and write ports between core and debug: core has fixed priority, with a starvation guard for debug.
- Optionally forwards same-cycle writes so read data is never stale.

Parameters:
- DBG_STARVE_LIMIT, 8, consecutive blocked debug-request cycles before the core is stalled for one cycle (legal range 1..255).
- NUM_REGS, 32, register count; sets the init sweep length (addresses 1..NUM_REGS-1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_rd_valid  in  1  core read request this cycle
- core_rs1  in  5  core read address, port 1
- core_rs2  in  5  core read address, port 2
- core_wr_valid  in  1  core write request
- core_rd  in  5  core write address
- core_wdata  in  32  core write data
- core_stall  out  1  core requests ignored this cycle; core must hold them
- core_rvalid  out  1  core read data valid (1 cycle after an accepted read)
- core_rdata1  out  32  read data, port 1
- core_rdata2  out  32  read data, port 2
- dbg_req  in  1  debug access request
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  5  debug register address
- dbg_wdata  in  32  debug write data
- dbg_ready  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  32  debug read data
- init_done  out  1  init sweep complete
- rf_addr1  out  5  register file read address 1
- rf_addr2  out  5  register file read address 2
- rf_addr3  out  5  register file write address
- rf_regwrite  out  1  register file write enable
- rf_datain  out  32  register file write data
- rf_rdata1  in  32  register file read data 1
- rf_rdata2  in  32  register file read data 2

Behaviour:
- Clock is clk; reset is synchronous, active-high (reset).
- Reset values:
  - State INIT, init counter = 1, init_done = 0.
  - core_rvalid = 0, dbg_rvalid = 0.
  - Starvation counter = 0, force_dbg = 0.
  - core_rdata1/2 and dbg_rdata pass through or are muxed from register file data; their value is don't-care while the matching valid is 0.
- FSM states: INIT, RUN.
- INIT:
  - rf_regwrite = 1, rf_addr3 = counter, rf_datain = 0; counter increments every cycle.
  - When counter == NUM_REGS-1, the write completes, then RUN is entered and init_done goes to 1 on the next cycle. Total 31 cycles.
  - core_stall = 1, dbg_ready = 0.
  - Reset asserted mid-INIT restarts the sweep at 1.
- RUN, core read:
  - If core_rd_valid && !core_stall: rf_addr1 = core_rs1, rf_addr2 = core_rs2.
  - core_rvalid = 1 the next cycle, with core_rdata1/2 = rf_rdata1/2.
- RUN, core write:
  - If core_wr_valid && !core_stall: rf_addr3 = core_rd, rf_datain = core_wdata, rf_regwrite = 1.
- RUN, debug grant:
  - A debug read is granted when !core_rd_valid || force_dbg. It uses rf_addr2 = dbg_addr; dbg_rvalid = 1 the next cycle with dbg_rdata = rf_rdata2.
  - A debug write is granted when !core_wr_valid || force_dbg.
  - dbg_ready = grant (combinational).
- Simultaneous core and debug requests: the core wins unless force_dbg = 1.
- Starvation guard:
  - The counter increments while dbg_req && !dbg_ready and clears on any grant or when dbg_req is low.
  - When the counter reaches DBG_STARVE_LIMIT-1 and the request is still blocked, force_dbg is set.
  - In the next cycle: core_stall = 1, debug is granted, force_dbg clears and the counter clears.
  - core_stall = (state == INIT) || force_dbg.
- Address 0:
  - Writes are passed through; the register file discards them.
  - The arbiter never forwards a write to address 0 (see Optional Feature).
- Unused read ports drive address 0. rf_regwrite = 0 when there is no granted write.

Optional Feature:
- Macro: REGFILE_ARB_BYPASS_EN.
- Defined:
  - A granted write's address and data are registered at the same edge as the read capture.
  - On the return cycle, any returned read whose captured address equals the registered write address (nonzero, write valid) returns the write data instead of rf_rdata. This applies to core port 1, core port 2 and debug reads.
- Undefined:
  - Raw register file data is returned; a read issued in the same cycle as a write to the same register returns the old value.

Test Plan:
- Reset held 2 cycles, then released -> rf_regwrite high for addresses 1..31 with data 0 in consecutive cycles; init_done = 1 on cycle 32; core_stall = 1 throughout.
- RUN: core write x5 = 0xDEADBEEF, next cycle core read rs1 = 5, rs2 = 0 -> core_rvalid one cycle later, rdata1 = 0xDEADBEEF, rdata2 = 0.
- Same-cycle core write x7 = 0x12345678 and read rs1 = 7, prior value 0 -> rdata1 = 0x12345678 with REGFILE_ARB_BYPASS_EN defined, 0 without.
- dbg_req read x3 while core_rd_valid held high, DBG_STARVE_LIMIT = 8 -> dbg_ready = 0 for 8 cycles, then core_stall = 1 and dbg_ready = 1 in the 9th cycle; dbg_rvalid the following cycle; core read during the stall cycle ignored.
- Debug write x0 = 0xFFFFFFFF, then debug read x0 -> dbg_rdata = 0, including with bypass enabled.
- Reset asserted at init counter = 15 -> sweep restarts at address 1; init_done stays 0 until 31 cycles after the reset is released.
